// File: rtl/stage1_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input and the
// stage2 valid/ready instruction port. master = fetch stage, slave = its environment.
interface stage1_fetch_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            pipeline_valid;
  logic            ready;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr,
    output instr_pc,
    output pipeline_valid,
    input  ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  instr,
    input  instr_pc,
    input  pipeline_valid,
    output ready
  );
endinterface

// File: rtl/stage1_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order fetches and buffers
// returned words with their PCs in a small FIFO feeding decode over valid/ready.
module stage1_fetch #(
  parameter int unsigned     XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  stage1_fetch_if.master bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]     instr_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];

  logic [CntW:0]   inflight;
  logic [XLEN-1:0] target;
  logic            req_fire;
  logic            resp_hit;
  logic            push;
  logic            pop;

  // Buffered words plus requests in flight never exceed the FIFO, so a push can't overflow.
  assign inflight = {1'b0, count_q} + {1'b0, outst_q};
  assign target   = bus.redirect_pc & ~XLEN'(3);

  assign bus.imem_req_valid = (state_q == StRun) && (inflight < (CntW + 1)'(FIFO_DEPTH)) &&
                              !bus.redirect_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.pipeline_valid = (count_q != '0) && !bus.redirect_valid;
  assign bus.instr          = (count_q != '0) ? instr_mem[rd_ptr_q] : Nop;
  assign bus.instr_pc       = (count_q != '0) ? pc_mem[rd_ptr_q] : '0;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_hit = bus.imem_resp_valid && (outst_q != '0);
  assign push     = (state_q == StRun) && !bus.redirect_valid && resp_hit;
  assign pop      = bus.pipeline_valid && bus.ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    unique case (state_q)
      StIdle: state_d = StRun;
      StRun, StDrain: begin
        if (bus.redirect_valid) begin
          // A response landing with the redirect belongs to the old path and is dropped.
          fetch_pc_d = target;
          resp_pc_d  = target;
          count_d    = '0;
          rd_ptr_d   = '0;
          wr_ptr_d   = '0;
          outst_d    = outst_q - CntW'(resp_hit);
          state_d    = (outst_d != '0) ? StDrain : StRun;
        end else if (state_q == StDrain) begin
          outst_d = outst_q - CntW'(resp_hit);
          if (outst_d == '0) begin
            state_d = StRun;
          end
        end else begin
          if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
          end
          if (push) begin
            resp_pc_d = resp_pc_q + XLEN'(4);
            wr_ptr_d  = wr_ptr_q + PtrW'(1);
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
          end
          count_d = count_q + CntW'(push) - CntW'(pop);
          outst_d = outst_q + CntW'(req_fire) - CntW'(resp_hit);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.imem_resp_data;
      pc_mem[wr_ptr_q]    <= resp_pc_q;
    end
  end
endmodule
